// File: rtl/storage_tag_allocator_pkg.sv
// Shared types and defaults for the storage tag allocator slice.
// Op codes, FSM states and the response payload layout live here.
package storage_tag_allocator_pkg;

   localparam int unsigned TAG_WIDTH = 32;
   localparam int unsigned TAG_DEPTH = 3;
   localparam int unsigned TAG_SLOTS = 1 << TAG_DEPTH;

   typedef enum logic [1:0] {
      OP_LOOKUP       = 2'b00,
      OP_LOOKUP_ALLOC = 2'b01,
      OP_INVALIDATE   = 2'b10,
      OP_FLUSH        = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_FETCH,
      ST_CHECK,
      ST_WRITE,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic [TAG_DEPTH-1:0] idx;
      logic                 hit;
      logic                 alloc;
      logic                 evict;
   } resp_t;

endpackage

// File: rtl/storage_tag_allocator_if.sv
// Request/response handshake toward the core plus the mini_storage pin bundle.
// slave = allocator side, master = core/storage side.
interface storage_tag_allocator_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 3
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [WIDTH-1:0] req_key;
   logic             resp_valid;
   logic             resp_ready;
   logic [DEPTH-1:0] resp_idx;
   logic             resp_hit;
   logic             resp_alloc;
   logic             resp_evict;
   logic             st_en;
   logic             st_wren;
   logic             st_get_addr;
   logic [DEPTH-1:0] st_addr;
   logic [WIDTH-1:0] st_d;
   logic [WIDTH-1:0] st_q;

   modport slave (
      input  req_valid, req_op, req_key, resp_ready, st_q,
      output req_ready, resp_valid, resp_idx, resp_hit, resp_alloc, resp_evict,
             st_en, st_wren, st_get_addr, st_addr, st_d
   );

   modport master (
      output req_valid, req_op, req_key, resp_ready, st_q,
      input  req_ready, resp_valid, resp_idx, resp_hit, resp_alloc, resp_evict,
             st_en, st_wren, st_get_addr, st_addr, st_d
   );
endinterface

// File: rtl/storage_tag_allocator_free_slot_picker.sv
// Priority encoder: lowest-index cleared bit of the valid mask.
module storage_tag_allocator_free_slot_picker
   import storage_tag_allocator_pkg::*;
#(
   parameter int unsigned DEPTH = TAG_DEPTH
) (
   input  logic [(1<<DEPTH)-1:0] valid,
   output logic [DEPTH-1:0]      free_idx_c,
   output logic                  any_free_c
);
   localparam int unsigned SLOTS = 1 << DEPTH;

   // Scan downward so the lowest free index is the last one written.
   always_comb begin
      free_idx_c = '0;
      any_free_c = 1'b0;
      for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            free_idx_c = DEPTH'(i);
            any_free_c = 1'b1;
         end
      end
   end
endmodule

// File: rtl/storage_tag_allocator.sv
// Key-to-slot allocator driving an 8-entry mini_storage: search, read-back
// verify, valid mask, free-first / round-robin allocation, invalidate, flush.
module storage_tag_allocator
   import storage_tag_allocator_pkg::*;
#(
   parameter int unsigned WIDTH = TAG_WIDTH,
   parameter int unsigned DEPTH = TAG_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   storage_tag_allocator_if.slave  bus
);
   localparam int unsigned SLOTS = 1 << DEPTH;

   state_e           state_q, state_n;
   op_e              op_q, op_n;
   logic [WIDTH-1:0] key_q, key_n;
   logic [DEPTH-1:0] cand_q, cand_n;
   logic [DEPTH-1:0] rr_q, rr_n;
   logic [SLOTS-1:0] valid_q, valid_n;
   resp_t            resp_q, resp_n;
   logic             resp_valid_q, resp_valid_n;
   logic             req_ready_q, req_ready_n;
   logic             st_en_q, st_en_n;
   logic             st_wren_q, st_wren_n;
   logic             st_get_addr_q, st_get_addr_n;
   logic [DEPTH-1:0] st_addr_q, st_addr_n;
   logic [WIDTH-1:0] st_d_q, st_d_n;

   logic             same_c, hit_c, any_free_c;
   logic [DEPTH-1:0] free_idx_c, slot_c;

   storage_tag_allocator_free_slot_picker #(.DEPTH(DEPTH)) u_free (
      .valid      (valid_q),
      .free_idx_c (free_idx_c),
      .any_free_c (any_free_c)
   );

   // Read-back compare guards against stale search results and unwritten slots.
   assign same_c = (bus.st_q == key_q);
   assign hit_c  = same_c & valid_q[cand_q];
   assign slot_c = same_c ? cand_q : (any_free_c ? free_idx_c : rr_q);

   always_comb begin
      state_n       = state_q;
      op_n          = op_q;
      key_n         = key_q;
      cand_n        = cand_q;
      rr_n          = rr_q;
      valid_n       = valid_q;
      resp_n        = resp_q;
      resp_valid_n  = resp_valid_q;
      st_en_n       = 1'b0;
      st_wren_n     = 1'b0;
      st_get_addr_n = 1'b0;
      st_addr_n     = '0;
      st_d_n        = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               op_n  = op_e'(bus.req_op);
               key_n = bus.req_key;
               if (op_e'(bus.req_op) == OP_FLUSH) begin
                  valid_n      = '0;
                  resp_n       = '0;
                  resp_valid_n = 1'b1;
                  state_n      = ST_RESP;
               end else begin
                  st_en_n       = 1'b1;
                  st_get_addr_n = 1'b1;
                  st_d_n        = bus.req_key;
                  state_n       = ST_SEARCH;
               end
            end
         end
         ST_SEARCH: begin
            st_en_n = 1'b1;
            state_n = ST_FETCH;
         end
         ST_FETCH: begin
            cand_n  = bus.st_q[DEPTH-1:0];
            state_n = ST_CHECK;
         end
         ST_CHECK: begin
            resp_n.hit   = hit_c;
            resp_n.alloc = 1'b0;
            resp_n.evict = 1'b0;
            resp_n.idx   = cand_q;
            resp_valid_n = 1'b1;
            state_n      = ST_RESP;
            case (op_q)
               OP_LOOKUP: begin
                  if (!hit_c) resp_n.idx = '0;
               end
               OP_INVALIDATE: begin
                  if (hit_c) valid_n[cand_q] = 1'b0;
               end
               default: begin
                  if (!hit_c) begin
                     resp_n.idx   = slot_c;
                     resp_n.alloc = 1'b1;
                     resp_n.evict = !same_c && !any_free_c;
                     resp_valid_n = 1'b0;
                     st_en_n      = 1'b1;
                     st_wren_n    = 1'b1;
                     st_addr_n    = slot_c;
                     st_d_n       = key_q;
                     state_n      = ST_WRITE;
                  end
               end
            endcase
         end
         ST_WRITE: begin
            // Commit only once the write strobe has been issued for a full cycle.
            valid_n[resp_q.idx] = 1'b1;
            if (resp_q.evict) rr_n = rr_q + DEPTH'(1);
            resp_valid_n = 1'b1;
            state_n      = ST_RESP;
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               resp_valid_n = 1'b0;
               state_n      = ST_IDLE;
            end
         end
         default: begin
            resp_valid_n = 1'b0;
            state_n      = ST_IDLE;
         end
      endcase

      req_ready_n = (state_n == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         op_q          <= OP_LOOKUP;
         key_q         <= '0;
         cand_q        <= '0;
         rr_q          <= '0;
         valid_q       <= '0;
         resp_q        <= '0;
         resp_valid_q  <= 1'b0;
         req_ready_q   <= 1'b1;
         st_en_q       <= 1'b0;
         st_wren_q     <= 1'b0;
         st_get_addr_q <= 1'b0;
         st_addr_q     <= '0;
         st_d_q        <= '0;
      end else begin
         state_q       <= state_n;
         op_q          <= op_n;
         key_q         <= key_n;
         cand_q        <= cand_n;
         rr_q          <= rr_n;
         valid_q       <= valid_n;
         resp_q        <= resp_n;
         resp_valid_q  <= resp_valid_n;
         req_ready_q   <= req_ready_n;
         st_en_q       <= st_en_n;
         st_wren_q     <= st_wren_n;
         st_get_addr_q <= st_get_addr_n;
         st_addr_q     <= st_addr_n;
         st_d_q        <= st_d_n;
      end
   end

   // Search result lands in st_q at FETCH and is used as the read address that same cycle.
   assign bus.st_addr     = (state_q == ST_FETCH) ? bus.st_q[DEPTH-1:0] : st_addr_q;
   assign bus.st_en       = st_en_q;
   assign bus.st_wren     = st_wren_q;
   assign bus.st_get_addr = st_get_addr_q;
   assign bus.st_d        = st_d_q;
   assign bus.req_ready   = req_ready_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_idx    = resp_q.idx;
   assign bus.resp_hit    = resp_q.hit;
   assign bus.resp_alloc  = resp_q.alloc;
   assign bus.resp_evict  = resp_q.evict;
endmodule

// File: tb/tb_storage_tag_allocator.sv
// Bench for storage_tag_allocator with a behavioural mini_storage and a
// slot-table reference model checked every cycle a response is presented.
module tb_storage_tag_allocator;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   storage_tag_allocator_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   storage_tag_allocator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // mini_storage: write, associative search (highest match wins, q held on miss), read
   logic [WIDTH-1:0] mem [8];
   logic [WIDTH-1:0] q;
   assign bus.st_q = q;
   always @(posedge clk) begin
      if (bus.st_en) begin
         if (bus.st_wren) mem[bus.st_addr] <= bus.st_d;
         else if (bus.st_get_addr) begin
            for (int i = 0; i < 8; i++)
               if (mem[i] == bus.st_d) q <= WIDTH'(i);
         end else q <= mem[bus.st_addr];
      end
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: what each slot holds and whether it is live
   typedef struct {
      int   lat;
      int   idx;
      logic hit;
      logic alloc;
      logic evict;
      logic chk_idx;
   } exp_t;

   logic [WIDTH-1:0] m_mem [8];
   bit               m_valid [8];
   int               m_rr;
   exp_t             exp_q[$];

   task automatic model_op(input logic [1:0] op, input logic [WIDTH-1:0] key, output exp_t e);
      int found;
      int slot;
      logic hit;
      e = '{lat: 4, idx: 0, hit: 1'b0, alloc: 1'b0, evict: 1'b0, chk_idx: 1'b1};
      if (op == 2'b11) begin
         for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
         e.lat = 1;
         return;
      end
      found = -1;
      for (int i = 0; i < 8; i++) if (m_mem[i] == key) found = i;
      hit = (found >= 0) && m_valid[found];
      e.hit = hit;
      if (op == 2'b00) begin
         e.idx = hit ? found : 0;
      end else if (op == 2'b10) begin
         if (hit) begin
            m_valid[found] = 1'b0;
            e.idx = found;
         end else e.chk_idx = 1'b0;
      end else if (hit) begin
         e.idx = found;
      end else begin
         slot = -1;
         if (found >= 0) slot = found;
         else for (int i = 7; i >= 0; i--) if (!m_valid[i]) slot = i;
         if (slot < 0) begin
            slot    = m_rr;
            e.evict = 1'b1;
            m_rr    = (m_rr + 1) % 8;
         end
         m_mem[slot]   = key;
         m_valid[slot] = 1'b1;
         e.idx   = slot;
         e.alloc = 1'b1;
         e.lat   = 5;
      end
   endtask

   // Compare process: every cycle with a response (or a pending op) is checked
   int cyc = 0;
   int acc_cyc = 0;
   int last_lat = 0;
   bit seen = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         cyc++;
         if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
         if (exp_q.size() > 0)
            check("no_stray_write", 64'(bus.st_wren & ~exp_q[0].alloc), 64'd0);
         if (bus.resp_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_resp: got resp_valid 1, expected 0");
            end else begin
               if (!seen) begin
                  check("latency", 64'(cyc - acc_cyc), 64'(exp_q[0].lat));
                  last_lat = cyc - acc_cyc;
                  seen = 1'b1;
               end
               if (exp_q[0].chk_idx) check("resp_idx", 64'(bus.resp_idx), 64'(exp_q[0].idx));
               check("resp_hit",   64'(bus.resp_hit),   64'(exp_q[0].hit));
               check("resp_alloc", 64'(bus.resp_alloc), 64'(exp_q[0].alloc));
               check("resp_evict", 64'(bus.resp_evict), 64'(exp_q[0].evict));
               check("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
            end
         end
      end
   end

   logic [DEPTH-1:0] cap_idx;
   logic cap_hit, cap_alloc, cap_evict;

   task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] key, input int hold);
      exp_t e;
      int k;
      model_op(op, key, e);
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.req_valid  = 1'b1;
      bus.req_op     = op;
      bus.req_key    = key;
      bus.resp_ready = (hold == 0);
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.req_ready && k < 20);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.resp_valid && k < 20);
      if (!bus.resp_valid) begin
         tests++;
         fails++;
         $display("FAIL resp_timeout: got no response, expected one within 20 cycles");
         exp_q.delete();
         bus.resp_ready = 1'b1;
         return;
      end
      repeat (hold) @(negedge clk);
      bus.resp_ready = 1'b1;
      cap_idx   = bus.resp_idx;
      cap_hit   = bus.resp_hit;
      cap_alloc = bus.resp_alloc;
      cap_evict = bus.resp_evict;
      @(posedge clk); #1;
      void'(exp_q.pop_front());
      seen = 1'b0;
      check("resp_dropped", 64'(bus.resp_valid), 64'd0);
      check("req_ready_after", 64'(bus.req_ready), 64'd1);
   endtask

   task automatic pin(input string name, input int lat, input int idx,
                      input logic hit, input logic alloc, input logic evict);
      check({name, "_lat"},   64'(last_lat),  64'(lat));
      check({name, "_idx"},   64'(cap_idx),   64'(idx));
      check({name, "_hit"},   64'(cap_hit),   64'(hit));
      check({name, "_alloc"}, 64'(cap_alloc), 64'(alloc));
      check({name, "_evict"}, 64'(cap_evict), 64'(evict));
   endtask

   initial begin
      int k;
      // Never-written contents; slot5 happens to hold 0xA5 but is not valid
      for (int i = 0; i < 8; i++) begin
         mem[i]     = 32'hDEAD_BE00 | 32'(i);
         m_mem[i]   = mem[i];
         m_valid[i] = 1'b0;
      end
      mem[5]   = 32'h0000_00A5;
      m_mem[5] = 32'h0000_00A5;
      m_rr     = 0;
      q        = '0;
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_op     = 2'b00;
      bus.req_key    = '0;
      bus.resp_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_req_ready",  64'(bus.req_ready),  64'd1);
      check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rst_st_en",      64'(bus.st_en),      64'd0);
      check("rst_st_wren",    64'(bus.st_wren),    64'd0);
      check("rst_resp_idx",   64'(bus.resp_idx),   64'd0);
      @(posedge clk); #1 rst = 1'b0;

      do_op(2'b00, 32'hA5, 0);  pin("lookup_a5", 4, 0, 0, 0, 0);
      do_op(2'b01, 32'h11, 0);  pin("alloc_11",  5, 0, 0, 1, 0);
      do_op(2'b01, 32'h22, 0);  pin("alloc_22",  5, 1, 0, 1, 0);
      do_op(2'b01, 32'h33, 0);  pin("alloc_33",  5, 2, 0, 1, 0);
      do_op(2'b00, 32'h22, 0);  pin("lookup_22", 4, 1, 1, 0, 0);
      do_op(2'b10, 32'h22, 0);  pin("inval_22",  4, 1, 1, 0, 0);
      do_op(2'b01, 32'h22, 0);  pin("revive_22", 5, 1, 0, 1, 0);
      do_op(2'b00, 32'h22, 0);  pin("relook_22", 4, 1, 1, 0, 0);
      do_op(2'b01, 32'h44, 0);  pin("alloc_44",  5, 3, 0, 1, 0);
      for (int i = 5; i <= 8; i++) do_op(2'b01, 32'(i * 32'h11), 0);
      do_op(2'b01, 32'h99, 0);  pin("evict_99",  5, 0, 0, 1, 1);
      do_op(2'b01, 32'hAA, 0);  pin("evict_aa",  5, 1, 0, 1, 1);
      do_op(2'b00, 32'h11, 0);  pin("gone_11",   4, 0, 0, 0, 0);
      do_op(2'b11, 32'h0,  0);  pin("flush",     1, 0, 0, 0, 0);
      do_op(2'b00, 32'h33, 0);  pin("post_flush_33", 4, 0, 0, 0, 0);
      do_op(2'b01, 32'h33, 0);  pin("revive_33", 5, 2, 0, 1, 0);
      do_op(2'b00, 32'h33, 5);  pin("hold_33",   4, 2, 1, 0, 0);

      // Abort an allocation while its write strobe is out
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b01;
      bus.req_key   = 32'hBB;
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.req_ready && k < 20);
      @(posedge clk); #1 bus.req_valid = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.st_wren && k < 20);
      check("abort_reached_write", 64'(bus.st_wren), 64'd1);
      #1 rst = 1'b1;
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_rr = 0;
      #1;
      check("abort_wren_cleared", 64'(bus.st_wren),    64'd0);
      check("abort_resp_valid",   64'(bus.resp_valid), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      seen = 1'b0;
      @(negedge clk);
      check("abort_req_ready",  64'(bus.req_ready),  64'd1);
      check("abort_resp_idle",  64'(bus.resp_valid), 64'd0);

      do_op(2'b00, 32'hBB, 0);  pin("abort_bb",  4, 0, 0, 0, 0);
      do_op(2'b00, 32'h33, 0);  pin("abort_33",  4, 0, 0, 0, 0);
      do_op(2'b01, 32'hBB, 0);  pin("realloc_bb", 5, 0, 0, 1, 0);
      do_op(2'b01, 32'hCC, 0);  pin("alloc_cc",  5, 1, 0, 1, 0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end
endmodule
